// File: rtl/iob_sseg_scan_pkg.sv
// ----------------------------------------------------------------------------
// iob_sseg_scan_pkg
// Shared constants for the seven-segment scan driver.
//   SSEG_0..SSEG_F : active-low gfedcba patterns for hex digits 0..F
//   SSEG_OFF       : all cathodes off (dp included)
//   SSEG_DP_BIT    : position of the decimal point within the cathode byte
// ----------------------------------------------------------------------------
package iob_sseg_scan_pkg;

    localparam logic [6:0] SSEG_0 = 7'h40;
    localparam logic [6:0] SSEG_1 = 7'h79;
    localparam logic [6:0] SSEG_2 = 7'h24;
    localparam logic [6:0] SSEG_3 = 7'h30;
    localparam logic [6:0] SSEG_4 = 7'h19;
    localparam logic [6:0] SSEG_5 = 7'h12;
    localparam logic [6:0] SSEG_6 = 7'h02;
    localparam logic [6:0] SSEG_7 = 7'h78;
    localparam logic [6:0] SSEG_8 = 7'h00;
    localparam logic [6:0] SSEG_9 = 7'h10;
    localparam logic [6:0] SSEG_A = 7'h08;
    localparam logic [6:0] SSEG_B = 7'h03;
    localparam logic [6:0] SSEG_C = 7'h46;
    localparam logic [6:0] SSEG_D = 7'h21;
    localparam logic [6:0] SSEG_E = 7'h06;
    localparam logic [6:0] SSEG_F = 7'h0E;

    localparam logic [7:0] SSEG_OFF    = 8'hFF;
    localparam int         SSEG_DP_BIT = 7;

    // Build the active-low cathode byte from a decimal-point flag (1 = lit)
    // and an active-low segment pattern.
    function automatic logic [7:0] sseg_cathodes(input logic dp_lit,
                                                 input logic [6:0] seg);
        logic [7:0] c;
        c              = {1'b1, seg};
        c[SSEG_DP_BIT] = ~dp_lit;
        return c;
    endfunction

endpackage

// File: rtl/iob_sseg_hex_dec.sv
// ----------------------------------------------------------------------------
// iob_sseg_hex_dec
// Combinational hex-to-seven-segment decoder.
//   nib_i  in  4  hex nibble
//   seg_o  out 7  gfedcba, active-low
// ----------------------------------------------------------------------------
module iob_sseg_hex_dec
    import iob_sseg_scan_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SSEG_8;
        unique case (nib_i)
            4'h0: seg_o = SSEG_0;
            4'h1: seg_o = SSEG_1;
            4'h2: seg_o = SSEG_2;
            4'h3: seg_o = SSEG_3;
            4'h4: seg_o = SSEG_4;
            4'h5: seg_o = SSEG_5;
            4'h6: seg_o = SSEG_6;
            4'h7: seg_o = SSEG_7;
            4'h8: seg_o = SSEG_8;
            4'h9: seg_o = SSEG_9;
            4'hA: seg_o = SSEG_A;
            4'hB: seg_o = SSEG_B;
            4'hC: seg_o = SSEG_C;
            4'hD: seg_o = SSEG_D;
            4'hE: seg_o = SSEG_E;
            4'hF: seg_o = SSEG_F;
        endcase
    end

endmodule

// File: rtl/iob_sseg_scan.sv
// ----------------------------------------------------------------------------
// iob_sseg_scan
// Time-multiplexed seven-segment driver. A frame (hex nibbles, decimal
// points, blank mask) is accepted over valid/ready into a shadow register
// and copied to the active register only at a frame boundary, so a frame
// being displayed never tears.
//   clk      in   1        system clock
//   rst      in   1        asynchronous reset, active-high
//   en_i     in   1        scan enable
//   valid_i  in   1        frame offered
//   ready_o  out  1        frame can be accepted
//   data_i   in   4*NDIG   digit k = data_i[4k+3:4k]
//   dp_i     in   NDIG     decimal point per digit, 1 = lit
//   blank_i  in   NDIG     1 = digit dark
//   frame_o  out  1        one-cycle pulse after each frame wrap
//   ca_o     out  8        cathodes, active-low, ca_o[7] = dp
//   an_o     out  NDIG     anodes, active-low
// ----------------------------------------------------------------------------
module iob_sseg_scan
    import iob_sseg_scan_pkg::*;
#(
    parameter int NDIG  = 8,
    parameter int DIV   = 100000,
    parameter int BLANK = 1000,
    parameter int DIV_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [4*NDIG-1:0] data_i,
    input  logic [NDIG-1:0]   dp_i,
    input  logic [NDIG-1:0]   blank_i,
    output logic              frame_o,
    output logic [7:0]        ca_o,
    output logic [NDIG-1:0]   an_o
);

    localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_V  = DIV_W'(BLANK);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NDIG - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]  presc_q,    presc_d;
    logic [DIG_W-1:0]  dig_q,      dig_d;
    logic              pend_q,     pend_d;
    logic              ready_q,    ready_d;
    logic              frame_q,    frame_d;
    logic [7:0]        ca_q,       ca_d;
    logic [NDIG-1:0]   an_q,       an_d;

    logic [4*NDIG-1:0] sh_data_q,  sh_data_d;
    logic [NDIG-1:0]   sh_dp_q,    sh_dp_d;
    logic [NDIG-1:0]   sh_blank_q, sh_blank_d;
    logic [4*NDIG-1:0] act_data_q, act_data_d;
    logic [NDIG-1:0]   act_dp_q,   act_dp_d;
    logic [NDIG-1:0]   act_blank_q, act_blank_d;

    // ------------------------------------------------------------------
    // Scan timing and handshake
    // ------------------------------------------------------------------
    logic tick, wrap, xfer, apply;

    always_comb begin
        tick  = en_i && (presc_q == DIV_LAST);
        wrap  = tick && (dig_q == DIG_LAST);
        xfer  = valid_i && ready_q;
        // When scanning, a pending frame waits for the frame boundary;
        // when idle there is nothing to tear, so it applies immediately.
        apply = pend_q && (!en_i || wrap);

        presc_d = presc_q;
        dig_d   = dig_q;
        if (!en_i) begin
            presc_d = '0;
            dig_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            dig_d   = wrap ? '0 : dig_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        frame_d = wrap;
    end

    // ------------------------------------------------------------------
    // Shadow / active frames and pending flag.
    // xfer needs ready (pending clear) and apply needs pending set, so the
    // two never coincide; a transfer on the wrapping tick therefore lands
    // in the shadow and waits for the following wrap.
    // ------------------------------------------------------------------
    always_comb begin
        sh_data_d   = sh_data_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        pend_d      = pend_q;

        if (apply) begin
            act_data_d  = sh_data_q;
            act_dp_d    = sh_dp_q;
            act_blank_d = sh_blank_q;
            pend_d      = 1'b0;
        end

        if (xfer) begin
            sh_data_d  = data_i;
            sh_dp_d    = dp_i;
            sh_blank_d = blank_i;
            pend_d     = 1'b1;
        end

        ready_d = !pend_d;
    end

    // ------------------------------------------------------------------
    // Current digit selection and output encoding
    // ------------------------------------------------------------------
    logic [3:0]      cur_nib;
    logic            cur_dp;
    logic            cur_blank;
    logic [NDIG-1:0] sel_an;
    logic [6:0]      cur_seg;
    logic            dark;

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        sel_an    = '1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (dig_q == DIG_W'(k)) begin
                cur_nib   = act_data_q[4*k +: 4];
                cur_dp    = act_dp_q[k];
                cur_blank = act_blank_q[k];
                sel_an[k] = 1'b0;
            end
        end
    end

    iob_sseg_hex_dec u_hex_dec (
        .nib_i (cur_nib),
        .seg_o (cur_seg)
    );

    always_comb begin
        dark = !en_i || (presc_q < BLANK_V) || cur_blank;
        an_d = dark ? '1 : sel_an;
        ca_d = dark ? SSEG_OFF : sseg_cathodes(cur_dp, cur_seg);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            dig_q       <= '0;
            pend_q      <= 1'b0;
            ready_q     <= 1'b1;
            frame_q     <= 1'b0;
            ca_q        <= SSEG_OFF;
            an_q        <= '1;
            sh_data_q   <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '1;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '1;
        end else begin
            presc_q     <= presc_d;
            dig_q       <= dig_d;
            pend_q      <= pend_d;
            ready_q     <= ready_d;
            frame_q     <= frame_d;
            ca_q        <= ca_d;
            an_q        <= an_d;
            sh_data_q   <= sh_data_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
        end
    end

    assign ready_o = ready_q;
    assign frame_o = frame_q;
    assign ca_o    = ca_q;
    assign an_o    = an_q;

endmodule

// File: tb/tb_iob_sseg_scan.sv
module tb_iob_sseg_scan;

    localparam int NDIG  = 8;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int DIV_W = 2;
    localparam int FRAME = NDIG * DIV;

    logic              clk = 1'b0;
    logic              rst;
    logic              en_i;
    logic              valid_i;
    logic              ready_o;
    logic [4*NDIG-1:0] data_i;
    logic [NDIG-1:0]   dp_i;
    logic [NDIG-1:0]   blank_i;
    logic              frame_o;
    logic [7:0]        ca_o;
    logic [NDIG-1:0]   an_o;

    iob_sseg_scan #(
        .NDIG  (NDIG),
        .DIV   (DIV),
        .BLANK (BLANK),
        .DIV_W (DIV_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .dp_i    (dp_i),
        .blank_i (blank_i),
        .frame_o (frame_o),
        .ca_o    (ca_o),
        .an_o    (an_o)
    );

    always #5 clk = ~clk;

    // Segment table, 0..F, active-low gfedcba
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: scan position is just "cycles since enable"; frames
    // are held as shadow/active copies plus a pending flag.
    int unsigned       m_t;
    logic              m_pend;
    logic [4*NDIG-1:0] m_sh_data,  m_act_data;
    logic [NDIG-1:0]   m_sh_dp,    m_act_dp;
    logic [NDIG-1:0]   m_sh_blank, m_act_blank;

    task automatic model_reset();
        m_t         = 0;
        m_pend      = 1'b0;
        m_sh_data   = '0;
        m_sh_dp     = '0;
        m_sh_blank  = '1;
        m_act_data  = '0;
        m_act_dp    = '0;
        m_act_blank = '1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h required=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance model on the edge, compare outputs 1 time unit later.
    task automatic step();
        int unsigned     dig, pres;
        logic            dark, wrap, xfer, apply;
        logic [7:0]      e_ca;
        logic [NDIG-1:0] e_an;
        logic [3:0]      nib;
        @(posedge clk);
        dig  = (m_t / DIV) % NDIG;
        pres = m_t % DIV;
        wrap = en_i && ((m_t % FRAME) == FRAME - 1);
        dark = !en_i || (pres < BLANK) || m_act_blank[dig];
        nib  = m_act_data[4*dig +: 4];
        e_an = dark ? '1 : ~(NDIG'(1) << dig);
        e_ca = dark ? 8'hFF : {~m_act_dp[dig], hex_tab[nib]};
        xfer  = valid_i && !m_pend;
        apply = m_pend && (!en_i || wrap);
        if (apply) begin
            m_act_data  = m_sh_data;
            m_act_dp    = m_sh_dp;
            m_act_blank = m_sh_blank;
            m_pend      = 1'b0;
        end
        if (xfer) begin
            m_sh_data  = data_i;
            m_sh_dp    = dp_i;
            m_sh_blank = blank_i;
            m_pend     = 1'b1;
        end
        m_t = en_i ? m_t + 1 : 0;
        #1;
        chk("ca_o",    32'(ca_o),    32'(e_ca));
        chk("an_o",    32'(an_o),    32'(e_an));
        chk("frame_o", 32'(frame_o), 32'(wrap));
        chk("ready_o", 32'(ready_o), 32'(!m_pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
        valid_i = 1'b1;
        data_i  = d;
        dp_i    = dp;
        blank_i = bl;
        step();
        valid_i = 1'b0;
    endtask

    initial begin
        bit found;
        rst     = 1'b1;
        en_i    = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        dp_i    = '0;
        blank_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ca",    32'(ca_o),    32'hFF);
        chk("rst_an",    32'(an_o),    32'hFF);
        chk("rst_ready", 32'(ready_o), 32'h1);
        chk("rst_frame", 32'(frame_o), 32'h0);
        rst = 1'b0;

        // Load a frame while idle: applies the cycle after transfer.
        run(2);
        offer(32'h76543210, 8'h00, 8'h00);
        run(3);

        // Scan: includes no frame pulse for the first 31 cycles.
        en_i = 1'b1;
        run(40);

        // Tear-free: offer all-F while digit 3 is being scanned, then hold
        // valid with other data while ready is low (must be ignored).
        found = 0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            if (((m_t / DIV) % NDIG) == 3) begin found = 1; break; end
            step();
        end
        chk("wait_dig3", 32'(found), 32'h1);
        offer(32'hFFFFFFFF, 8'h00, 8'h00);
        valid_i = 1'b1;
        for (int n = 0; n < 6; n++) begin
            data_i = $urandom;
            step();
        end
        valid_i = 1'b0;
        run(50);

        // Transfer coincident with the wrapping tick: applies one frame later.
        found = 0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            if (((m_t % FRAME) == FRAME - 1) && !m_pend) begin found = 1; break; end
            step();
        end
        chk("wait_wrap", 32'(found), 32'h1);
        offer(32'h11111111, 8'h00, 8'h00);
        run(70);

        // Blank / dp.
        offer(32'h00000000, 8'h01, 8'h02);
        run(70);

        // Disable mid-frame, transfer while idle, re-enable.
        run(13);
        en_i = 1'b0;
        run(3);
        offer(32'hA5C3E1B7, 8'h81, 8'h10);
        run(3);
        en_i = 1'b1;
        run(40);

        // Asynchronous reset mid-scan.
        offer(32'h89ABCDEF, 8'h55, 8'h00);
        run(37);
        rst = 1'b1;
        #1;
        chk("arst_ca",    32'(ca_o),    32'hFF);
        chk("arst_an",    32'(an_o),    32'hFF);
        chk("arst_ready", 32'(ready_o), 32'h1);
        chk("arst_frame", 32'(frame_o), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        run(40);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            en_i    = ($urandom_range(0, 39) != 0);
            valid_i = ($urandom_range(0, 3) == 0);
            data_i  = $urandom;
            dp_i    = NDIG'($urandom);
            blank_i = NDIG'($urandom & $urandom & $urandom);
            step();
        end
        valid_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
